// File: rtl/riscv_boot_pkg.sv
// Shared types and constants for the RISC-V boot sequencer: FSM state encoding,
// stream framing sizes and the values every output register takes in reset.
package riscv_boot_pkg;

  typedef enum logic [2:0] {
    ST_HDR0 = 3'd0,
    ST_HDR1 = 3'd1,
    ST_DATA = 3'd2,
    ST_CHK  = 3'd3,
    ST_RUN  = 3'd4,
    ST_ERR  = 3'd5
  } boot_state_e;

  localparam int HDR_BYTES  = 2;
  localparam int WORD_BYTES = 4;

  localparam logic        RST_CPU_RESET  = 1'b1;
  localparam logic        RST_IMEM_WE    = 1'b0;
  localparam logic [31:0] RST_IMEM_WDATA = 32'h0000_0000;
  localparam logic        RST_BOOT_DONE  = 1'b0;
  localparam logic        RST_BOOT_ERR   = 1'b0;

endpackage

// File: rtl/riscv_boot_sequencer_if.sv
// Byte-stream input and instruction-memory write port of the boot sequencer.
// The sequencer is the slave side; the link/bench is the master side.
interface riscv_boot_sequencer_if #(
  parameter int ADDR_W = 10
) ();

  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output rx_valid,
    output rx_data,
    input  rx_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );

  modport slave (
    input  rx_valid,
    input  rx_data,
    output rx_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );

endinterface

// File: rtl/riscv_boot_sequencer_word_assembler.sv
// Packs accepted data bytes little-endian into 32-bit words and flags the byte
// that completes a word; the completed word is presented combinationally.
module boot_word_assembler
  import riscv_boot_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_byte_en,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_valid
);

  localparam int IDX_W = $clog2(WORD_BYTES);

  logic [IDX_W-1:0] r_byte_idx;
  logic [31:0]      r_lane;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_byte_idx <= '0;
      r_lane     <= '0;
    end else if (i_byte_en) begin
      r_lane[8*r_byte_idx +: 8] <= i_byte;
      r_byte_idx                <= r_byte_idx + IDX_W'(1);
    end
  end

  assign o_word_valid = i_byte_en && (r_byte_idx == IDX_W'(WORD_BYTES - 1));

  // The top lane comes straight from the incoming byte so the word is ready on its last edge.
  always_comb begin
    o_word                          = r_lane;
    o_word[8*(WORD_BYTES-1) +: 8]   = i_byte;
  end

endmodule

// File: rtl/riscv_boot_sequencer.sv
// Boot sequencer: holds the CPU in reset, loads a counted word image into IMEM,
// then releases the CPU. Optional trailing XOR checksum under `BOOT_CHECKSUM_EN.
module riscv_boot_sequencer
  import riscv_boot_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  riscv_boot_sequencer_if.slave   bus,
  output logic                    o_cpu_reset,
  output logic                    o_boot_done,
  output logic                    o_boot_err
);

  localparam int unsigned CAPACITY = 32'd1 << ADDR_W;

  boot_state_e       r_state;
  logic [CNT_W-1:0]  r_count;
  logic [ADDR_W-1:0] r_word_idx;
  logic              r_imem_we;
  logic [ADDR_W-1:0] r_imem_addr;
  logic [31:0]       r_imem_wdata;
  logic              r_cpu_reset;
  logic              r_boot_done;
  logic              r_boot_err;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]        r_xsum;
`endif

  logic              w_rx_ready;
  logic              w_accept;
  logic              w_data_byte;
  logic [31:0]       w_word;
  logic              w_word_valid;
  logic [CNT_W-1:0]  w_hdr_count;
  logic              w_count_over;
  logic              w_count_zero;
  logic              w_last_word;

  always_comb begin
    w_rx_ready = 1'b0;
    case (r_state)
      ST_HDR0, ST_HDR1, ST_DATA, ST_CHK: w_rx_ready = 1'b1;
      default:                           w_rx_ready = 1'b0;
    endcase
  end

  assign w_accept     = bus.rx_valid && w_rx_ready;
  assign w_data_byte  = w_accept && (r_state == ST_DATA);
  assign w_hdr_count  = {bus.rx_data, r_count[7:0]};
  assign w_count_over = 32'(w_hdr_count) > CAPACITY;
  assign w_count_zero = (w_hdr_count == '0);
  assign w_last_word  = (CNT_W'(r_word_idx) + CNT_W'(1)) == r_count;

  boot_word_assembler u_asm (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_byte_en    (w_data_byte),
    .i_byte       (bus.rx_data),
    .o_word       (w_word),
    .o_word_valid (w_word_valid)
  );

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state      <= ST_HDR0;
      r_count      <= '0;
      r_word_idx   <= '0;
      r_imem_we    <= RST_IMEM_WE;
      r_imem_addr  <= '0;
      r_imem_wdata <= RST_IMEM_WDATA;
      r_cpu_reset  <= RST_CPU_RESET;
      r_boot_done  <= RST_BOOT_DONE;
      r_boot_err   <= RST_BOOT_ERR;
`ifdef BOOT_CHECKSUM_EN
      r_xsum       <= '0;
`endif
    end else begin
      r_imem_we <= 1'b0;
      case (r_state)
        ST_HDR0: begin
          if (w_accept) begin
            r_count[7:0] <= bus.rx_data;
            r_state      <= ST_HDR1;
          end
        end
        ST_HDR1: begin
          if (w_accept) begin
            r_count <= w_hdr_count;
            if (w_count_over) begin
              r_state    <= ST_ERR;
              r_boot_err <= 1'b1;
            end else if (w_count_zero) begin
`ifdef BOOT_CHECKSUM_EN
              r_state <= ST_CHK;
`else
              r_state     <= ST_RUN;
              r_cpu_reset <= 1'b0;
              r_boot_done <= 1'b1;
`endif
            end else begin
              r_state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (w_accept) begin
`ifdef BOOT_CHECKSUM_EN
            r_xsum <= r_xsum ^ bus.rx_data;
`endif
            if (w_word_valid) begin
              r_imem_we    <= 1'b1;
              r_imem_addr  <= r_word_idx;
              r_imem_wdata <= w_word;
              r_word_idx   <= r_word_idx + ADDR_W'(1);
              // Releasing the CPU on this edge lets its first fetch follow the final write.
              if (w_last_word) begin
`ifdef BOOT_CHECKSUM_EN
                r_state <= ST_CHK;
`else
                r_state     <= ST_RUN;
                r_cpu_reset <= 1'b0;
                r_boot_done <= 1'b1;
`endif
              end
            end
          end
        end
`ifdef BOOT_CHECKSUM_EN
        ST_CHK: begin
          if (w_accept) begin
            if (bus.rx_data == r_xsum) begin
              r_state     <= ST_RUN;
              r_cpu_reset <= 1'b0;
              r_boot_done <= 1'b1;
            end else begin
              r_state    <= ST_ERR;
              r_boot_err <= 1'b1;
            end
          end
        end
`endif
        ST_RUN: begin
          r_cpu_reset <= 1'b0;
          r_boot_done <= 1'b1;
        end
        ST_ERR: begin
          r_cpu_reset <= 1'b1;
          r_boot_err  <= 1'b1;
        end
        default: begin
          r_state     <= ST_ERR;
          r_cpu_reset <= 1'b1;
          r_boot_err  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.rx_ready   = w_rx_ready;
  assign bus.imem_we    = r_imem_we;
  assign bus.imem_addr  = r_imem_addr;
  assign bus.imem_wdata = r_imem_wdata;
  assign o_cpu_reset    = r_cpu_reset;
  assign o_boot_done    = r_boot_done;
  assign o_boot_err     = r_boot_err;

endmodule

// File: tb/tb_riscv_boot_sequencer.sv
// Directed bench for riscv_boot_sequencer; covers default build and, when
// BOOT_CHECKSUM_EN is defined, the checksum trailer paths.
module tb_riscv_boot_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cpu_reset, boot_done, boot_err;

  riscv_boot_sequencer_if #(.ADDR_W(10)) bus ();

  riscv_boot_sequencer #(.ADDR_W(10), .CNT_W(16)) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .bus         (bus),
    .o_cpu_reset (cpu_reset),
    .o_boot_done (boot_done),
    .o_boot_err  (boot_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n_wr  = 0;
  logic [9:0]  wr_addr [0:15];
  logic [31:0] wr_data [0:15];
  logic [7:0]  q [$];

  // Every cycle with imem_we high is logged, so a stretched pulse shows up as an extra write.
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      if (n_wr < 16) begin
        wr_addr[n_wr] = bus.imem_addr;
        wr_data[n_wr] = bus.imem_wdata;
      end
      n_wr = n_wr + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'($urandom);
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    for (int i = 0; i < gap; i++) idle();
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(posedge clk);
  endtask

  task automatic send_q(input int maxgap);
    foreach (q[i]) send(q[i], $urandom_range(0, maxgap));
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.rx_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cpu_reset"}, cpu_reset, 1'b1);
    check({tag, "_we"},        bus.imem_we, 1'b0);
    check({tag, "_addr"},      bus.imem_addr, 10'd0);
    check({tag, "_wdata"},     bus.imem_wdata, 32'h0);
    check({tag, "_done"},      boot_done, 1'b0);
    check({tag, "_err"},       boot_err, 1'b0);
    check({tag, "_rx_ready"},  bus.rx_ready, 1'b1);
  endtask

  task automatic image1(input string tag, input int maxgap);
    n_wr = 0;
    q = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00};
    send_q(maxgap);
    idle();
    check({tag, "_w0_we"},        bus.imem_we, 1'b1);
    check({tag, "_w0_cpu_reset"}, cpu_reset, 1'b1);
    check({tag, "_w0_done"},      boot_done, 1'b0);
    q = '{8'h93, 8'h05, 8'h10, 8'h00};
    send_q(maxgap);
`ifdef BOOT_CHECKSUM_EN
    send(8'h30, $urandom_range(0, maxgap));
`endif
    idle();
`ifndef BOOT_CHECKSUM_EN
    check({tag, "_w1_we"},        bus.imem_we, 1'b1);
    check({tag, "_w1_addr"},      bus.imem_addr, 10'd1);
`endif
    check({tag, "_run_cpu_reset"}, cpu_reset, 1'b0);
    check({tag, "_run_done"},      boot_done, 1'b1);
    idle();
    idle();
    check({tag, "_n_writes"},   n_wr, 2);
    check({tag, "_addr0"},      wr_addr[0], 10'd0);
    check({tag, "_data0"},      wr_data[0], 32'h00A0_0513);
    check({tag, "_addr1"},      wr_addr[1], 10'd1);
    check({tag, "_data1"},      wr_data[1], 32'h0010_0593);
    check({tag, "_run_ready"},  bus.rx_ready, 1'b0);
    check({tag, "_run_we"},     bus.imem_we, 1'b0);
    check({tag, "_run_err"},    boot_err, 1'b0);
    for (int i = 0; i < 4; i++) send(8'hFF, 0);
    idle();
    check({tag, "_run_ignore"}, n_wr, 2);
    check({tag, "_run_hold"},   boot_done, 1'b1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    check_reset_vals("por");

    image1("t1", 0);

    do_reset();
    check_reset_vals("t3_rst");
    image1("t3", 5);

    do_reset();
    n_wr = 0;
    q = '{8'h00, 8'h00};
    send_q(0);
    idle();
`ifndef BOOT_CHECKSUM_EN
    check("t2_done",      boot_done, 1'b1);
    check("t2_cpu_reset", cpu_reset, 1'b0);
`else
    check("t2_chk_wait",  boot_done, 1'b0);
    check("t2_chk_ready", bus.rx_ready, 1'b1);
    send(8'h00, 0);
    idle();
    check("t2_done",      boot_done, 1'b1);
    check("t2_cpu_reset", cpu_reset, 1'b0);
    do_reset();
    q = '{8'h00, 8'h00, 8'h01};
    send_q(0);
    idle();
    check("t2_bad_err",       boot_err, 1'b1);
    check("t2_bad_cpu_reset", cpu_reset, 1'b1);
    check("t2_bad_done",      boot_done, 1'b0);
`endif
    check("t2_no_write", n_wr, 0);

    do_reset();
    n_wr = 0;
    q = '{8'h01, 8'h04};
    send_q(0);
    idle();
    check("t4_err",       boot_err, 1'b1);
    check("t4_ready",     bus.rx_ready, 1'b0);
    check("t4_cpu_reset", cpu_reset, 1'b1);
    check("t4_done",      boot_done, 1'b0);
    q = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_q(0);
    idle();
    check("t4_no_write",  n_wr, 0);
    check("t4_err_hold",  boot_err, 1'b1);

    do_reset();
    q = '{8'h00, 8'h04};
    send_q(0);
    idle();
    check("t4_cap_err",   boot_err, 1'b0);
    check("t4_cap_ready", bus.rx_ready, 1'b1);

    do_reset();
    n_wr = 0;
    q = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_q(0);
    idle();
    check("t5_first_word", n_wr, 1);
    check("t5_first_data", wr_data[0], 32'h4433_2211);
    do_reset();
    check_reset_vals("t5_rst");
    n_wr = 0;
    q = '{8'h01, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_q(2);
`ifdef BOOT_CHECKSUM_EN
    send(8'h22, 0);
`endif
    idle();
    idle();
    check("t5_n_writes", n_wr, 1);
    check("t5_addr0",    wr_addr[0], 10'd0);
    check("t5_data0",    wr_data[0], 32'hEFBE_ADDE);
    check("t5_done",     boot_done, 1'b1);

`ifdef BOOT_CHECKSUM_EN
    do_reset();
    n_wr = 0;
    q = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    send_q(0);
    idle();
    check("t6_good_done", boot_done, 1'b1);
    check("t6_good_cpu",  cpu_reset, 1'b0);
    check("t6_good_data", wr_data[0], 32'h4433_2211);
    do_reset();
    q = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
    send_q(0);
    idle();
    check("t6_bad_err",  boot_err, 1'b1);
    check("t6_bad_cpu",  cpu_reset, 1'b1);
    check("t6_bad_done", boot_done, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/riscv_boot_sequencer.md
Name: riscv_boot_sequencer

Overview:
Power-up controller for the single-cycle RISC-V CPU. It holds the CPU in reset and receives a program image as a byte stream (UART/debug link). It assembles bytes into 32-bit little-endian words, writes them sequentially into instruction memory, then releases the CPU to execute from PC 0. It owns the instruction-memory write port and the CPU reset line.

Parameters:
ADDR_W, 10, word-address width of instruction memory; capacity is 2**ADDR_W words.
CNT_W, 16, width of the header word-count field. Fixed at 2 bytes; do not change.

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset (0 = reset asserted)
rx_valid  input  1  byte-stream valid
rx_data  input  8  byte-stream data
rx_ready  output  1  sequencer can accept a byte
imem_we  output  1  instruction-memory write enable, one-cycle pulse per word
imem_addr  output  ADDR_W  word address of write
imem_wdata  output  32  word to write
cpu_reset  output  1  active-high reset to CPU; 1 = CPU held
boot_done  output  1  image loaded, CPU running
boot_err  output  1  image rejected, CPU held

Behaviour:
- Reset (reset==0 at clk edge):
  - State = HDR0.
  - cpu_reset=1; imem_we=0; imem_addr=0; imem_wdata=0; boot_done=0; boot_err=0.
  - Byte index, word counter and XOR accumulator cleared.
  - Any partial word is discarded. Words already written remain in memory.
- Byte acceptance: a byte is accepted when rx_valid && rx_ready at the clk edge. rx_ready is a combinational decode of state: 1 in HDR0, HDR1, DATA and CHK; 0 in RUN and ERR.
- Stream format: count_lo, count_hi, then count×4 data bytes (little-endian per word, LSB first), then [checksum byte].
- States:
  - HDR0: accept byte -> count[7:0]; go to HDR1.
  - HDR1: accept byte -> count[15:8].
    - If full count > 2**ADDR_W: go to ERR.
    - Else if count == 0: go to CHK if BOOT_CHECKSUM_EN is defined, else RUN.
    - Else go to DATA.
  - DATA: each accepted byte goes into lane byte_idx (0..3) of the assembly register; byte_idx increments.
    - On the 4th byte (byte_idx==3), the registered outputs update on that edge: imem_wdata = assembled word, imem_addr = word_idx, imem_we = 1 for the following cycle only.
    - byte_idx wraps to 0; word_idx increments.
    - If word_idx+1 == count: leave DATA on the same edge (to CHK or RUN).
    - A byte accepted in the cycle imem_we is high is legal; the write uses the latched word.
  - CHK: accept one byte. If it equals the XOR of all data bytes, go to RUN; else go to ERR.
  - RUN: terminal. cpu_reset=0, boot_done=1; these are registered outputs, valid the first cycle in RUN. Only reset leaves RUN.
  - ERR: terminal. boot_err=1, cpu_reset=1; only reset leaves ERR.
- Timing: when the final word's 4th byte is accepted at edge T, imem_we is high in cycle T+1 and cpu_reset falls in cycle T+1 (no checksum). The CPU therefore leaves reset in the same cycle as the last write; memory writes on the edge ending T+1, before the CPU's first fetch is registered.
- rx_valid gaps of any length stall without side effects. Bytes presented while rx_ready=0 are ignored.
- imem_we is never high in RUN after its entry cycle, or in ERR.

Optional Feature:
- BOOT_CHECKSUM_EN
  - Defined: the CHK state exists. An 8-bit XOR accumulator over data bytes only (header excluded, cleared by reset) is compared with the trailing byte. Mismatch -> ERR.
  - Not defined: no CHK state, no accumulator; DATA/HDR1 go directly to RUN. boot_err is asserted only for count overflow.

Decomposition:
- Shared package riscv_boot_pkg holds:
  - the state enum (HDR0, HDR1, DATA, CHK, RUN, ERR)
  - the HDR_BYTES=2 and WORD_BYTES=4 constants
  - the reset-value constants.
- One sub-module, boot_word_assembler: byte_idx counter, 32-bit shift/lane register and word_valid pulse. The FSM, counters, checksum and output registers stay in the top.

Test Plan:
1. Stream 02 00 13 05 A0 00 93 05 10 00 -> writes addr0=0x00A00513, addr1=0x00100593, each imem_we exactly 1 cycle; cpu_reset=0 and boot_done=1 in the cycle of the second write.
2. Stream 00 00 (checksum off) -> no imem_we; boot_done=1 one cycle after the HDR1 byte. With checksum on, the trailing byte 00 -> boot_done; byte 01 -> boot_err.
3. Test 1 repeated with random 0–5 cycle rx_valid gaps plus junk rx_data while rx_valid=0 -> identical writes and addresses.
4. Header 01 04 (count 0x401, ADDR_W=10) -> boot_err=1, rx_ready=0, cpu_reset stays 1, no imem_we.
5. Reset (0 for 1 cycle) after 2 of the 4 bytes of word 1 -> outputs return to reset values, state HDR0. Re-sending a full one-word image writes it to addr0.
6. BOOT_CHECKSUM_EN, one word 11 22 33 44, trailer 44 (XOR) -> RUN. Trailer 45 -> ERR, cpu_reset=1.
